// File: rtl/mdio_phy_responder.sv
// PHY-side clause-22 MDIO responder: decodes generator frames, strobes
// register-file writes and serialises read data back on mdio_in.
//
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   mdc             management clock, sampled on clk (period >= 4 clk)
//   mdio_oe/out     generator-driven line and its enable
//   rd_data         register-file read data for addr
//   mdio_in/_en     serial read data back to the generator, and its enable
//   addr, wr_data   REGAD and write data of the last accepted frame
//   wr_stb, rd_req  1-clk write strobe / read request
//   mdio_done       1-clk pulse on a completed frame
//   frame_err       1-clk pulse on an aborted frame
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR = 5'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_oe,
    input  logic        mdio_out,
    input  logic [15:0] rd_data,
    output logic        mdio_in,
    output logic        mdio_in_en,
    output logic [4:0]  addr,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        rd_req,
    output logic        mdio_done,
    output logic        frame_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_SKIP  = 3'd4;

    logic [2:0]  state;
    logic [5:0]  cnt;
    logic        mdc_q;
    logic [14:0] sh;
    logic [15:0] osh;

    logic        rise;
    logic [13:0] hdr;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic        hdr_bad;
    logic        ta_bad;

    assign rise = mdc & ~mdc_q;

    // hdr is the full 14-bit header including the bit on this rise
    assign hdr     = {sh[12:0], mdio_out};
    assign st      = hdr[13:12];
    assign op      = hdr[11:10];
    assign phyad   = hdr[9:5];
    assign regad   = hdr[4:0];
    assign hdr_bad = (st != 2'b01) || (op == 2'b00) || (op == 2'b11);

    // TA from the generator must read 1 then 0 on a write
    assign ta_bad = ((cnt == 6'd14) && !mdio_out)
                 || ((cnt == 6'd15) &&  mdio_out);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 6'd0;
            mdc_q      <= 1'b0;
            sh         <= 15'd0;
            osh        <= 16'd0;
            mdio_in    <= 1'b0;
            mdio_in_en <= 1'b0;
            addr       <= 5'd0;
            wr_data    <= 16'd0;
            wr_stb     <= 1'b0;
            rd_req     <= 1'b0;
            mdio_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mdc_q     <= mdc;
            wr_stb    <= 1'b0;
            rd_req    <= 1'b0;
            mdio_done <= 1'b0;
            frame_err <= 1'b0;
            if (rise) begin
                case (state)
                    S_IDLE: begin
                        // only a driven 0 is a start bit; preamble 1s idle
                        if (mdio_oe && !mdio_out) begin
                            state <= S_HDR;
                            cnt   <= 6'd1;
                            sh    <= 15'd0;
                        end
                    end
                    S_HDR: begin
                        cnt <= cnt + 6'd1;
                        sh  <= {sh[13:0], mdio_out};
                        if (!mdio_oe) begin
                            state     <= S_IDLE;
                            cnt       <= 6'd0;
                            frame_err <= 1'b1;
                        end else if (cnt == 6'd13) begin
                            if (hdr_bad) begin
                                state     <= S_IDLE;
                                cnt       <= 6'd0;
                                frame_err <= 1'b1;
                            end else if (phyad != PHY_ADDR) begin
                                state <= S_SKIP;
                            end else begin
                                addr <= regad;
                                if (op == 2'b01) begin
                                    state <= S_WDATA;
                                end else begin
                                    state  <= S_RDATA;
                                    rd_req <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WDATA: begin
                        cnt <= cnt + 6'd1;
                        sh  <= {sh[13:0], mdio_out};
                        if (!mdio_oe || ta_bad) begin
                            state     <= S_IDLE;
                            cnt       <= 6'd0;
                            frame_err <= 1'b1;
                        end else if (cnt == 6'd31) begin
                            wr_data   <= {sh, mdio_out};
                            wr_stb    <= 1'b1;
                            mdio_done <= 1'b1;
                            state     <= S_IDLE;
                            cnt       <= 6'd0;
                        end
                    end
                    S_RDATA: begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd15) begin
                            // second TA bit: take the line and drive 0
                            osh        <= rd_data;
                            mdio_in    <= 1'b0;
                            mdio_in_en <= 1'b1;
                        end else if (cnt == 6'd32) begin
                            mdio_in    <= 1'b0;
                            mdio_in_en <= 1'b0;
                            mdio_done  <= 1'b1;
                            state      <= S_IDLE;
                            cnt        <= 6'd0;
                        end else if (cnt >= 6'd16) begin
                            mdio_in <= osh[15];
                            osh     <= {osh[14:0], 1'b0};
                        end
                    end
                    S_SKIP: begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= S_IDLE;
                            cnt   <= 6'd0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= 6'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: directed vector table,
// reset/back-to-back sequences and randomized frames against a frame model.
module tb_mdio_phy_responder;

    localparam logic [4:0] PHY = 5'h15;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdc;
    logic        mdio_oe;
    logic        mdio_out;
    logic [15:0] rd_data;
    logic        mdio_in;
    logic        mdio_in_en;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        rd_req;
    logic        mdio_done;
    logic        frame_err;

    mdio_phy_responder #(.PHY_ADDR(PHY)) dut (
        .clk        (clk),
        .reset      (reset),
        .mdc        (mdc),
        .mdio_oe    (mdio_oe),
        .mdio_out   (mdio_out),
        .rd_data    (rd_data),
        .mdio_in    (mdio_in),
        .mdio_in_en (mdio_in_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .wr_stb     (wr_stb),
        .rd_req     (rd_req),
        .mdio_done  (mdio_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] frame;
        int          drop;
        logic [15:0] rdd;
    } stim_t;

    typedef struct {
        int          n_wr;
        int          n_done;
        int          n_err;
        int          n_rd;
        int          err_bit;
        int          nrises;
        bit          is_read;
        logic [4:0]  addr;
        logic [15:0] wd;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int cnt_wr, cnt_done, cnt_err, cnt_rd;
    int err_at, done_at, bad_pulse;
    int cur_rise;

    logic [4:0]  m_addr;
    logic [15:0] m_wd;

    always @(negedge clk) begin
        if (wr_stb) cnt_wr++;
        if (rd_req) cnt_rd++;
        if (mdio_done) begin
            cnt_done++;
            done_at = cur_rise;
        end
        if (frame_err) begin
            cnt_err++;
            err_at = cur_rise;
        end
        if ((wr_stb && !mdio_done) || (frame_err && mdio_done))
            bad_pulse++;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        cnt_wr  = 0;
        cnt_done = 0;
        cnt_err = 0;
        cnt_rd  = 0;
        err_at  = 0;
        done_at = 0;
    endtask

    // one MDC period: data set up while low, DUT sees the rise next clk
    task automatic mdc_bit(input logic oe, input logic d, input int b);
        @(posedge clk);
        #1;
        mdc      = 1'b0;
        mdio_oe  = oe;
        mdio_out = d;
        repeat (2) @(posedge clk);
        #1;
        cur_rise = b;
        mdc      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // frame-level model: decode fields and find where the frame ends
    function automatic exp_t model(input stim_t s,
                                   input logic [4:0] a0,
                                   input logic [15:0] w0);
        exp_t e;
        logic [1:0] st, op, ta;
        e = '{n_wr: 0, n_done: 0, n_err: 0, n_rd: 0, err_bit: 0,
              nrises: 32, is_read: 0, addr: a0, wd: w0};
        st = s.frame[31:30];
        op = s.frame[29:28];
        ta = s.frame[17:16];
        if (s.drop >= 2 && s.drop <= 14) begin
            e.n_err = 1;
            e.err_bit = s.drop;
            e.nrises = s.drop;
        end else if (st != 2'b01 || op == 2'b00 || op == 2'b11) begin
            e.n_err = 1;
            e.err_bit = 14;
            e.nrises = 14;
        end else if (s.frame[27:23] != PHY) begin
            e.nrises = 32;
        end else if (op == 2'b10) begin
            e.addr = s.frame[22:18];
            e.n_rd = 1;
            e.n_done = 1;
            e.is_read = 1;
            e.nrises = 33;
        end else begin
            e.addr = s.frame[22:18];
            for (int b = 15; b <= 32; b++) begin
                if (e.n_err == 0) begin
                    if (b >= s.drop || (b == 15 && ta[1] != 1'b1)
                        || (b == 16 && ta[0] != 1'b0)) begin
                        e.n_err = 1;
                        e.err_bit = b;
                        e.nrises = b;
                    end
                end
            end
            if (e.n_err == 0) begin
                e.wd = s.frame[15:0];
                e.n_wr = 1;
                e.n_done = 1;
            end
        end
        return e;
    endfunction

    task automatic run_frame(input stim_t s, input exp_t e);
        logic oe, d, x_en, x_in;
        clr_mon();
        rd_data = s.rdd;
        for (int b = 1; b <= e.nrises; b++) begin
            oe = (e.is_read && b >= 15) ? 1'b0 : (b < s.drop);
            d  = (b <= 32) ? s.frame[32-b] : 1'b0;
            mdc_bit(oe, d, b);
            x_en = e.is_read && b >= 16 && b <= 32;
            x_in = (e.is_read && b >= 17 && b <= 32) ? s.rdd[32-b] : 1'b0;
            chk("rise_en", {31'd0, mdio_in_en}, {31'd0, x_en});
            chk("rise_in", {31'd0, mdio_in}, {31'd0, x_in});
        end
        repeat (2) @(posedge clk);
        #1;
        chk("wr_stb_cnt", cnt_wr, e.n_wr);
        chk("done_cnt", cnt_done, e.n_done);
        chk("err_cnt", cnt_err, e.n_err);
        chk("rd_req_cnt", cnt_rd, e.n_rd);
        chk("err_bit", err_at, e.err_bit);
        if (e.n_done != 0)
            chk("done_bit", done_at, e.is_read ? 33 : 32);
        chk("addr", {27'd0, addr}, {27'd0, e.addr});
        chk("wr_data", {16'd0, wr_data}, {16'd0, e.wd});
        m_addr = e.addr;
        m_wd   = e.wd;
    endtask

    function automatic vec_t mkv(input logic [31:0] f, input int dr,
                                 input logic [15:0] rdd,
                                 input int wr, input int dn,
                                 input int er, input int rq,
                                 input int eb, input int nr,
                                 input bit rf, input logic [4:0] a,
                                 input logic [15:0] wd);
        vec_t v;
        v.s = '{frame: f, drop: dr, rdd: rdd};
        v.e = '{n_wr: wr, n_done: dn, n_err: er, n_rd: rq,
                err_bit: eb, nrises: nr, is_read: rf, addr: a, wd: wd};
        return v;
    endfunction

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[10];
        stim_t s;
        exp_t  e;

        vecs[0] = mkv(32'h5ABA1234, 40, 16'h0000,
                      1, 1, 0, 0, 0, 32, 0, 5'h0E, 16'h1234);
        vecs[1] = mkv(32'h6AB80000, 40, 16'hBEEF,
                      0, 1, 0, 1, 0, 33, 1, 5'h0E, 16'h1234);
        vecs[2] = mkv(32'h51BA1234, 40, 16'h0000,
                      0, 0, 0, 0, 0, 32, 0, 5'h0E, 16'h1234);
        vecs[3] = mkv(32'h5ABA9999, 20, 16'h0000,
                      0, 0, 1, 0, 20, 20, 0, 5'h0E, 16'h1234);
        vecs[4] = mkv(32'h5ABA5678, 40, 16'h0000,
                      1, 1, 0, 0, 0, 32, 0, 5'h0E, 16'h5678);
        vecs[5] = mkv(32'h1ABA1234, 40, 16'h0000,
                      0, 0, 1, 0, 14, 14, 0, 5'h0E, 16'h5678);
        vecs[6] = mkv(32'h42BA1234, 40, 16'h0000,
                      0, 0, 1, 0, 14, 14, 0, 5'h0E, 16'h5678);
        vecs[7] = mkv(32'h5AB91234, 40, 16'h0000,
                      0, 0, 1, 0, 15, 15, 0, 5'h0E, 16'h5678);
        vecs[8] = mkv(32'h5AFEA5A5, 40, 16'h0000,
                      1, 1, 0, 0, 0, 32, 0, 5'h1F, 16'hA5A5);
        vecs[9] = mkv(32'h6A800000, 40, 16'h0001,
                      0, 1, 0, 1, 0, 33, 1, 5'h00, 16'hA5A5);

        bad_pulse = 0;
        cur_rise  = 0;
        clr_mon();
        reset    = 1'b0;
        mdc      = 1'b0;
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
        rd_data  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in", {31'd0, mdio_in}, 0);
        chk("rst_en", {31'd0, mdio_in_en}, 0);
        chk("rst_addr", {27'd0, addr}, 0);
        chk("rst_wd", {16'd0, wr_data}, 0);
        chk("rst_stb", {28'd0, wr_stb, rd_req, mdio_done, frame_err}, 0);
        reset = 1'b1;
        m_addr = 5'd0;
        m_wd   = 16'd0;

        // preamble of 1s must never start a frame
        for (int i = 0; i < 32; i++) mdc_bit(1'b1, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("preamble", cnt_wr + cnt_done + cnt_err + cnt_rd, 0);

        for (int i = 0; i < 10; i++) run_frame(vecs[i].s, vecs[i].e);

        // reset in the middle of a read's data phase
        clr_mon();
        rd_data = 16'hCAFE;
        s.frame = 32'h6AB80000;
        for (int b = 1; b <= 24; b++) mdc_bit(b < 15, s.frame[32-b], b);
        chk("mid_read_en", {31'd0, mdio_in_en}, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        mdc   = 1'b0;
        #1;
        chk("rst_mid_en", {31'd0, mdio_in_en}, 0);
        chk("rst_mid_addr", {27'd0, addr}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_pulses", cnt_wr + cnt_done + cnt_err, 0);
        reset  = 1'b1;
        m_addr = 5'd0;
        m_wd   = 16'd0;

        // write after reset, then back-to-back write and read
        s = '{frame: 32'h5ABA00C3, drop: 40, rdd: 16'h0};
        run_frame(s, model(s, m_addr, m_wd));
        s = '{frame: 32'h5AFE0042, drop: 40, rdd: 16'h0};
        run_frame(s, model(s, m_addr, m_wd));
        s = '{frame: 32'h6AB80000, drop: 40, rdd: 16'h1357};
        run_frame(s, model(s, m_addr, m_wd));

        for (int i = 0; i < 120; i++) begin
            s.frame = $urandom;
            s.frame[31] = 1'b0;
            if ($urandom_range(9) != 0) s.frame[30] = 1'b1;
            if ($urandom_range(4) != 0) s.frame[27:23] = PHY;
            if ($urandom_range(4) != 0) s.frame[17:16] = 2'b10;
            s.drop = ($urandom_range(7) == 0) ? $urandom_range(32, 2) : 40;
            s.rdd  = 16'($urandom);
            e = model(s, m_addr, m_wd);
            run_frame(s, e);
        end

        chk("pulse_overlap", bad_pulse, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
